// File: rtl/branch_resolver_pkg.sv
// Shared constants for the branch resolver: result bit positions, BHT reset
// counter, FSM encodings and the saturating-counter helper.
package branch_resolver_pkg;

  localparam int BRA_RESULT_WIDTH = 2;
  localparam int BRA_PRE_BIT      = 1;
  localparam int BRA_TAKEN_BIT    = 0;

  localparam logic [1:0] BHT_CTR_RESET = 2'b01;

  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_FLUSH = 1'b1;

  function automatic logic [1:0] bht_next(input logic [1:0] ctr, input logic taken);
    logic [1:0] nxt;
    if (taken) begin
      nxt = (ctr == 2'b11) ? 2'b11 : ctr + 2'b01;
    end else begin
      nxt = (ctr == 2'b00) ? 2'b00 : ctr - 2'b01;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/branch_bht.sv
// 2-bit saturating branch history table: one combinational lookup port and one
// commit-time update port. Only instantiated when BRA_BHT_EN is defined.
module branch_bht
  import branch_resolver_pkg::*;
#(
  parameter int PC_WIDTH        = 32,
  parameter int BHT_INDEX_WIDTH = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PC_WIDTH-1:0] pred_pc,
  output logic                pred_taken,
  input  logic                upd_valid,
  input  logic [PC_WIDTH-1:0] upd_pc,
  input  logic                upd_taken
);

  localparam int DEPTH = 1 << BHT_INDEX_WIDTH;

  logic [1:0]                 ctr_q [DEPTH];
  logic [1:0]                 ctr_d [DEPTH];
  logic [BHT_INDEX_WIDTH-1:0] rd_idx;
  logic [BHT_INDEX_WIDTH-1:0] wr_idx;
  logic                       unused_pc_bits;

  assign rd_idx = pred_pc[BHT_INDEX_WIDTH+1:2];
  assign wr_idx = upd_pc[BHT_INDEX_WIDTH+1:2];
  assign unused_pc_bits = ^{pred_pc[PC_WIDTH-1:BHT_INDEX_WIDTH+2], pred_pc[1:0],
                            upd_pc[PC_WIDTH-1:BHT_INDEX_WIDTH+2], upd_pc[1:0]};

  // Reads the registered counter, so a same-cycle update is not visible yet.
  assign pred_taken = ctr_q[rd_idx][1];

  always_comb begin
    ctr_d = ctr_q;
    if (upd_valid) begin
      ctr_d[wr_idx] = bht_next(ctr_q[wr_idx], upd_taken);
    end else begin
      ctr_d = ctr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        ctr_q[i] <= BHT_CTR_RESET;
      end
    end else begin
      ctr_q <= ctr_d;
    end
  end

endmodule

// File: rtl/branch_resolver.sv
// Branch result table indexed by ROB entry; checks results at commit and
// raises a one-cycle flush on mispredict. BHT present only with BRA_BHT_EN.
module branch_resolver
  import branch_resolver_pkg::*;
#(
  parameter int ROB_ENTRY_WIDTH = 4,
  parameter int PC_WIDTH        = 32,
  parameter int BHT_INDEX_WIDTH = 6
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        alloc_valid,
  input  logic [ROB_ENTRY_WIDTH-1:0]  alloc_index,
  input  logic [PC_WIDTH-1:0]         alloc_pc,
  input  logic [PC_WIDTH-1:0]         alloc_target,
  input  logic                        res_valid,
  input  logic [ROB_ENTRY_WIDTH-1:0]  res_index,
  input  logic [BRA_RESULT_WIDTH-1:0] res_result,
  input  logic                        commit_valid,
  input  logic [ROB_ENTRY_WIDTH-1:0]  commit_index,
  output logic                        commit_ready,
  input  logic [PC_WIDTH-1:0]         pred_pc,
  output logic                        pred_taken,
  output logic                        flush,
  output logic [PC_WIDTH-1:0]         flush_pc
);

  localparam int DEPTH = 1 << ROB_ENTRY_WIDTH;
  localparam logic [PC_WIDTH-1:0] PC_STEP = {{(PC_WIDTH-3){1'b0}}, 3'b100};

  logic [DEPTH-1:0]            alloc_q, alloc_d;
  logic [DEPTH-1:0]            resolved_q, resolved_d;
  logic [PC_WIDTH-1:0]         pc_q [DEPTH];
  logic [PC_WIDTH-1:0]         pc_d [DEPTH];
  logic [PC_WIDTH-1:0]         target_q [DEPTH];
  logic [PC_WIDTH-1:0]         target_d [DEPTH];
  logic [BRA_RESULT_WIDTH-1:0] result_q [DEPTH];
  logic [BRA_RESULT_WIDTH-1:0] result_d [DEPTH];
  logic [0:0]                  state_q, state_d;
  logic                        flush_q, flush_d;
  logic [PC_WIDTH-1:0]         flush_pc_q, flush_pc_d;

  logic                        run;
  logic                        cm_bypass;
  logic [BRA_RESULT_WIDTH-1:0] cm_result;
  logic                        cm_taken;
  logic                        mispredict;

  assign run          = (state_q == ST_RUN);
  assign cm_bypass    = res_valid && (res_index == commit_index);
  // A same-cycle result for the head entry is newer than anything stored.
  assign cm_result    = cm_bypass ? res_result : result_q[commit_index];
  assign cm_taken     = cm_result[BRA_TAKEN_BIT];
  assign commit_ready = run && commit_valid && alloc_q[commit_index] &&
                        (resolved_q[commit_index] || cm_bypass);
  assign mispredict   = commit_ready &&
                        (cm_result[BRA_PRE_BIT] != cm_result[BRA_TAKEN_BIT]);

  assign flush    = flush_q;
  assign flush_pc = flush_pc_q;

  // Entry table: alloc first so a same-cycle result on that entry lands on it.
  always_comb begin
    alloc_d    = alloc_q;
    resolved_d = resolved_q;
    pc_d       = pc_q;
    target_d   = target_q;
    result_d   = result_q;
    if (run) begin
      if (alloc_valid) begin
        alloc_d[alloc_index]    = 1'b1;
        resolved_d[alloc_index] = 1'b0;
        pc_d[alloc_index]       = alloc_pc;
        target_d[alloc_index]   = alloc_target;
      end else begin
        alloc_d = alloc_q;
      end
      if (res_valid && alloc_d[res_index]) begin
        resolved_d[res_index] = 1'b1;
        result_d[res_index]   = res_result;
      end else begin
        result_d = result_q;
      end
      if (commit_ready) begin
        alloc_d[commit_index]    = 1'b0;
        resolved_d[commit_index] = 1'b0;
      end else begin
        resolved_d = resolved_d;
      end
      if (mispredict) begin
        alloc_d    = '0;
        resolved_d = '0;
      end else begin
        alloc_d = alloc_d;
      end
    end else begin
      alloc_d = alloc_q;
    end
  end

  // RUN/FLUSH control and the registered redirect.
  always_comb begin
    state_d    = state_q;
    flush_d    = 1'b0;
    flush_pc_d = flush_pc_q;
    case (state_q)
      ST_RUN: begin
        if (mispredict) begin
          state_d    = ST_FLUSH;
          flush_d    = 1'b1;
          flush_pc_d = cm_taken ? target_q[commit_index] : pc_q[commit_index] + PC_STEP;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_FLUSH: begin
        state_d = ST_RUN;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // Control state with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      alloc_q    <= '0;
      resolved_q <= '0;
      state_q    <= ST_RUN;
      flush_q    <= 1'b0;
      flush_pc_q <= '0;
    end else begin
      alloc_q    <= alloc_d;
      resolved_q <= resolved_d;
      state_q    <= state_d;
      flush_q    <= flush_d;
      flush_pc_q <= flush_pc_d;
    end
  end

  // Entry payload is qualified by alloc/resolved, so it needs no reset.
  always_ff @(posedge clk) begin
    pc_q     <= pc_d;
    target_q <= target_d;
    result_q <= result_d;
  end

`ifdef BRA_BHT_EN
  branch_bht #(
    .PC_WIDTH        (PC_WIDTH),
    .BHT_INDEX_WIDTH (BHT_INDEX_WIDTH)
  ) u_bht (
    .clk        (clk),
    .rst        (rst),
    .pred_pc    (pred_pc),
    .pred_taken (pred_taken),
    .upd_valid  (commit_ready),
    .upd_pc     (pc_q[commit_index]),
    .upd_taken  (cm_taken)
  );
`else
  localparam int unused_bht_width = BHT_INDEX_WIDTH;
  logic unused_pred_pc;
  assign unused_pred_pc = ^pred_pc;
  assign pred_taken     = 1'b0;
`endif

endmodule

// File: tb/tb_branch_resolver.sv
// Self-checking bench for branch_resolver: directed scenarios then random
// traffic against a behavioural model of the entry table, FSM and BHT.
module tb_branch_resolver;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        alloc_valid;
  logic [3:0]  alloc_index;
  logic [31:0] alloc_pc;
  logic [31:0] alloc_target;
  logic        res_valid;
  logic [3:0]  res_index;
  logic [1:0]  res_result;
  logic        commit_valid;
  logic [3:0]  commit_index;
  logic        commit_ready;
  logic [31:0] pred_pc;
  logic        pred_taken;
  logic        flush;
  logic [31:0] flush_pc;

  always #5 clk = ~clk;

  branch_resolver #(
    .ROB_ENTRY_WIDTH (4),
    .PC_WIDTH        (32),
    .BHT_INDEX_WIDTH (6)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .alloc_valid  (alloc_valid),
    .alloc_index  (alloc_index),
    .alloc_pc     (alloc_pc),
    .alloc_target (alloc_target),
    .res_valid    (res_valid),
    .res_index    (res_index),
    .res_result   (res_result),
    .commit_valid (commit_valid),
    .commit_index (commit_index),
    .commit_ready (commit_ready),
    .pred_pc      (pred_pc),
    .pred_taken   (pred_taken),
    .flush        (flush),
    .flush_pc     (flush_pc)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Behavioural model
  bit          m_alloc    [DEPTH];
  bit          m_resolved [DEPTH];
  logic [1:0]  m_result   [DEPTH];
  logic [31:0] m_pc       [DEPTH];
  logic [31:0] m_tgt      [DEPTH];
  bit          m_in_flush;
  bit          m_flush;
  logic [31:0] m_flush_pc;
  int          m_ctr      [64];

  function automatic bit exp_ready();
    return !m_in_flush && commit_valid && m_alloc[commit_index] &&
           (m_resolved[commit_index] || (res_valid && res_index == commit_index));
  endfunction

  function automatic bit exp_pred();
`ifdef BRA_BHT_EN
    return m_ctr[pred_pc[7:2]] >= 2;
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_edge();
    bit          rdy;
    logic [1:0]  r;
    logic [31:0] cpc;
    logic [31:0] ctgt;
    int          ci;
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        m_alloc[i] = 0;
        m_resolved[i] = 0;
      end
      for (int i = 0; i < 64; i++) m_ctr[i] = 1;
      m_in_flush = 0;
      m_flush = 0;
      m_flush_pc = 32'h0;
    end else if (m_in_flush) begin
      m_in_flush = 0;
      m_flush = 0;
    end else begin
      ci   = commit_index;
      rdy  = exp_ready();
      r    = (res_valid && res_index == commit_index) ? res_result : m_result[ci];
      cpc  = m_pc[ci];
      ctgt = m_tgt[ci];
      m_flush = 0;
      if (alloc_valid) begin
        m_alloc[alloc_index] = 1;
        m_resolved[alloc_index] = 0;
        m_pc[alloc_index] = alloc_pc;
        m_tgt[alloc_index] = alloc_target;
      end
      if (res_valid && m_alloc[res_index]) begin
        m_resolved[res_index] = 1;
        m_result[res_index] = res_result;
      end
      if (rdy) begin
        m_alloc[ci] = 0;
        m_resolved[ci] = 0;
        if (r[0]) m_ctr[cpc[7:2]] = (m_ctr[cpc[7:2]] == 3) ? 3 : m_ctr[cpc[7:2]] + 1;
        else      m_ctr[cpc[7:2]] = (m_ctr[cpc[7:2]] == 0) ? 0 : m_ctr[cpc[7:2]] - 1;
        if (r[1] != r[0]) begin
          for (int i = 0; i < DEPTH; i++) begin
            m_alloc[i] = 0;
            m_resolved[i] = 0;
          end
          m_in_flush = 1;
          m_flush = 1;
          m_flush_pc = r[0] ? ctgt : cpc + 32'd4;
        end
      end
    end
  endtask

  task automatic cycle();
    #1;
    check_eq("commit_ready", {31'd0, commit_ready}, {31'd0, exp_ready()});
    check_eq("pred_taken", {31'd0, pred_taken}, {31'd0, exp_pred()});
    check_eq("flush", {31'd0, flush}, {31'd0, m_flush});
    if (m_flush) check_eq("flush_pc", flush_pc, m_flush_pc);
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle();
    alloc_valid = 0; res_valid = 0; commit_valid = 0;
  endtask

  task automatic do_alloc(input logic [3:0] idx, input logic [31:0] pc, input logic [31:0] tgt);
    alloc_valid = 1; alloc_index = idx; alloc_pc = pc; alloc_target = tgt;
  endtask

  task automatic do_res(input logic [3:0] idx, input logic [1:0] r);
    res_valid = 1; res_index = idx; res_result = r;
  endtask

  task automatic do_commit(input logic [3:0] idx);
    commit_valid = 1; commit_index = idx;
  endtask

  task automatic reset_cycles(input int n);
    rst = 0;
    repeat (n) begin
      @(posedge clk);
      model_edge();
    end
    @(negedge clk);
    rst = 1;
  endtask

  function automatic logic [31:0] pick_pc();
    case ($urandom_range(0, 3))
      0: return 32'h0000_0100;
      1: return 32'h0000_0104;
      2: return 32'hFFFF_FFFC;
      default: return $urandom() & 32'hFFFF_FFFC;
    endcase
  endfunction

  initial begin
    rst = 0;
    idle();
    alloc_index = 0; alloc_pc = 0; alloc_target = 0;
    res_index = 0; res_result = 0; commit_index = 0; pred_pc = 0;
    @(negedge clk);
    reset_cycles(2);

    // Reset state
    idle(); do_commit(4'd3); pred_pc = 32'h100;
    #1;
    check_eq("t1_ready", {31'd0, commit_ready}, 32'd0);
    check_eq("t1_pred", {31'd0, pred_taken}, 32'd0);
    check_eq("t1_flush", {31'd0, flush}, 32'd0);
    check_eq("t1_flush_pc", flush_pc, 32'd0);
    cycle();

    // Correct not-taken commit
    idle(); do_alloc(4'd2, 32'h100, 32'h200); cycle();
    idle(); do_res(4'd2, 2'b00); cycle();
    idle(); do_commit(4'd2);
    #1 check_eq("t2_ready", {31'd0, commit_ready}, 32'd1);
    cycle();
    idle();
    check_eq("t2_noflush", {31'd0, flush}, 32'd0);
    cycle();

    // Same-cycle result bypass, taken mispredict
    idle(); do_alloc(4'd5, 32'h100, 32'h200); cycle();
    idle(); do_res(4'd5, 2'b01); do_commit(4'd5);
    #1 check_eq("t3_ready", {31'd0, commit_ready}, 32'd1);
    cycle();
    idle();
    check_eq("t3_flush", {31'd0, flush}, 32'd1);
    check_eq("t3_flush_pc", flush_pc, 32'h200);
    cycle();
    check_eq("t3_flush_once", {31'd0, flush}, 32'd0);

    // Not-taken mispredict with pc+4 wrap, then inputs during FLUSH
    idle(); do_alloc(4'd7, 32'hFFFF_FFFC, 32'h40); cycle();
    idle(); do_alloc(4'd4, 32'h300, 32'h340); do_res(4'd4, 2'b00); cycle();
    idle(); do_res(4'd7, 2'b10); do_commit(4'd7); cycle();
    idle();
    check_eq("t4_flush", {31'd0, flush}, 32'd1);
    check_eq("t4_flush_pc", flush_pc, 32'h0);
    do_alloc(4'd9, 32'h500, 32'h540); do_res(4'd9, 2'b00); do_commit(4'd9);
    #1 check_eq("t6_ready_in_flush", {31'd0, commit_ready}, 32'd0);
    cycle();
    idle();
    check_eq("t6_flush_done", {31'd0, flush}, 32'd0);
    do_commit(4'd9);
    #1 check_eq("t6_alloc_ignored", {31'd0, commit_ready}, 32'd0);
    cycle();
    idle(); do_commit(4'd4);
    #1 check_eq("t6_entries_cleared", {31'd0, commit_ready}, 32'd0);
    cycle();

    // BHT training at pc 0x100
    reset_cycles(1);
    for (int k = 0; k < 2; k++) begin
      idle(); do_alloc(4'd1, 32'h100, 32'h180); cycle();
      idle(); do_res(4'd1, 2'b11); do_commit(4'd1); cycle();
    end
    idle(); pred_pc = 32'h100;
`ifdef BRA_BHT_EN
    #1 check_eq("t5_pred_taken", {31'd0, pred_taken}, 32'd1);
`else
    #1 check_eq("t5_pred_static", {31'd0, pred_taken}, 32'd0);
`endif
    cycle();
    for (int k = 0; k < 2; k++) begin
      idle(); do_alloc(4'd1, 32'h100, 32'h180); cycle();
      idle(); do_res(4'd1, 2'b00); do_commit(4'd1); cycle();
    end
    idle(); pred_pc = 32'h100;
    #1 check_eq("t5_pred_not_taken", {31'd0, pred_taken}, 32'd0);
    cycle();

    // Reset in the middle of a FLUSH cycle
    idle(); do_alloc(4'd6, 32'h500, 32'h600); cycle();
    idle(); do_res(4'd6, 2'b01); do_commit(4'd6); cycle();
    idle(); rst = 0;
    #1 check_eq("t7_flush_before_rst", {31'd0, flush}, 32'd1);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    rst = 1;
    check_eq("t7_flush_after_rst", {31'd0, flush}, 32'd0);
    do_alloc(4'd6, 32'h500, 32'h600); cycle();
    idle(); do_res(4'd6, 2'b00); do_commit(4'd6);
    #1 check_eq("t7_run_after_rst", {31'd0, commit_ready}, 32'd1);
    cycle();

    // Random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      rst          = ($urandom_range(0, 199) != 0);
      alloc_valid  = $urandom_range(0, 1);
      alloc_index  = 4'($urandom_range(0, 7));
      alloc_pc     = pick_pc();
      alloc_target = $urandom();
      res_valid    = $urandom_range(0, 1);
      res_index    = 4'($urandom_range(0, 7));
      res_result   = 2'($urandom_range(0, 3));
      commit_valid = $urandom_range(0, 1);
      commit_index = 4'($urandom_range(0, 7));
      pred_pc      = pick_pc();
      if (alloc_valid && commit_valid && alloc_index == commit_index) alloc_valid = 0;
      cycle();
    end
    rst = 1;
    idle();
    cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
